// File: rtl/tx_order_framer.sv
// -----------------------------------------------------------------------------
// tx_order_framer
//
// Buffers order records from the decision/timestamp stage in a small FIFO and
// serialises each one into a fixed byte frame on a ready/valid byte stream
// toward the TX MAC/UART. Records that arrive while the FIFO is full are
// dropped and counted.
//
// Frame layout (one byte per accepted beat):
//   0: SYNC_BYTE  1: addr  2: buysell  3..6: timestamp, MSB first
//   7: XOR of bytes 1..6 (only when TX_FRAMER_CHECKSUM_EN is defined)
//
// Build option:
//   TX_FRAMER_CHECKSUM_EN  defined   -> 8-byte frame, out_last on checksum
//                          undefined -> 7-byte frame, out_last on ts[7:0]
//
// Parameters:
//   DEPTH      FIFO entries (power of two, 2..16)
//   SYNC_BYTE  first byte of every frame
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   tx_addr       instrument address of the record
//   tx_buysell    action code (0 hold, 1 sell, 2 buy); hold records ignored
//   tx_timestamp  latency timestamp
//   tx_dv         record valid, single-cycle pulse
//   out_data      frame byte
//   out_valid     out_data valid
//   out_ready     sink accepts the byte this cycle
//   out_last      high with the final byte of a frame
//   drop_count    records dropped on FIFO full, saturating
//   fifo_level    current FIFO occupancy
//   busy          FIFO non-empty or frame in progress
// -----------------------------------------------------------------------------
module tx_order_framer #(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               tx_addr,
   input  logic [7:0]               tx_buysell,
   input  logic [31:0]              tx_timestamp,
   input  logic                     tx_dv,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic [15:0]              drop_count,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] LEVEL_FULL = PW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};

`ifdef TX_FRAMER_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'd7;
`else
   localparam logic [2:0] LAST_IDX = 3'd6;
`endif

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

`ifdef TX_FRAMER_CHECKSUM_EN
   // XOR over the payload bytes; the sync byte is deliberately excluded
   function automatic logic [7:0] frame_checksum(input logic [47:0] f);
      frame_checksum = f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
   endfunction
`endif

   // Select frame byte idx from a stored {addr, buysell, timestamp} record
   function automatic logic [7:0] frame_byte(input logic [47:0] f, input logic [2:0] idx);
      case (idx)
         3'd0:    frame_byte = SYNC_BYTE;
         3'd1:    frame_byte = f[47:40];
         3'd2:    frame_byte = f[39:32];
         3'd3:    frame_byte = f[31:24];
         3'd4:    frame_byte = f[23:16];
         3'd5:    frame_byte = f[15:8];
         3'd6:    frame_byte = f[7:0];
`ifdef TX_FRAMER_CHECKSUM_EN
         3'd7:    frame_byte = frame_checksum(f);
`endif
         default: frame_byte = 8'h00;
      endcase
   endfunction

   logic [47:0]   mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] level_r;
   logic [PW-1:0] level_n_s;
   logic [15:0]   drop_count_r;

   state_t        state_r;
   state_t        state_n_s;
   logic [2:0]    index_r;
   logic [2:0]    index_n_s;
   logic [47:0]   frame_r;
   logic [47:0]   frame_n_s;

   logic [7:0]    out_data_r;
   logic          out_valid_r;
   logic          out_last_r;
   logic          busy_r;

   logic          rec_s;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          drop_s;
   logic          pop_s;
   logic [47:0]   head_s;

   assign rec_s   = tx_dv && (tx_buysell != 8'h00);
   assign full_s  = (level_r == LEVEL_FULL);
   assign empty_s = (level_r == {PW{1'b0}});
   // Full is judged on the level at the edge, so a same-cycle pop never rescues a write
   assign push_s  = rec_s && !full_s;
   assign drop_s  = rec_s && full_s;
   assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {tx_addr, tx_buysell, tx_timestamp};
      end
   end

   // Occupancy after this edge's push/pop
   always_comb begin
      level_n_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_n_s = level_r + PTR_ONE;
         2'b01:   level_n_s = level_r - PTR_ONE;
         default: level_n_s = level_r;
      endcase
   end

   // FIFO pointers, level and drop counter
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         level_r      <= {PW{1'b0}};
         drop_count_r <= 16'h0000;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r <= level_n_s;
         if (drop_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'd1;
         end
      end
   end

   // Frame sequencer: next state, byte index, frame register and FIFO pop
   always_comb begin
      state_n_s = state_r;
      index_n_s = index_r;
      frame_n_s = frame_r;
      pop_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s) begin
               pop_s     = 1'b1;
               frame_n_s = head_s;
               index_n_s = 3'd0;
               state_n_s = ST_SEND;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (out_valid_r && out_ready) begin
               if (index_r < LAST_IDX) begin
                  index_n_s = index_r + 3'd1;
               end else if (!empty_s) begin
                  // Chain straight into the next frame with no idle beat
                  pop_s     = 1'b1;
                  frame_n_s = head_s;
                  index_n_s = 3'd0;
               end else begin
                  index_n_s = 3'd0;
                  state_n_s = ST_IDLE;
               end
            end else begin
               state_n_s = ST_SEND;
            end
         end
         default: begin
            state_n_s = ST_IDLE;
            index_n_s = 3'd0;
         end
      endcase
   end

   // Sequencer state and registered stream outputs (derived from next state so they stay stable while stalled)
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         index_r     <= 3'd0;
         frame_r     <= 48'h0;
         out_valid_r <= 1'b0;
         out_data_r  <= 8'h00;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n_s;
         index_r     <= index_n_s;
         frame_r     <= frame_n_s;
         out_valid_r <= (state_n_s == ST_SEND);
         out_data_r  <= (state_n_s == ST_SEND) ? frame_byte(frame_n_s, index_n_s) : 8'h00;
         out_last_r  <= (state_n_s == ST_SEND) && (index_n_s == LAST_IDX);
         busy_r      <= (level_n_s != {PW{1'b0}}) || (state_n_s == ST_SEND);
      end
   end

   assign out_data   = out_data_r;
   assign out_valid  = out_valid_r;
   assign out_last   = out_last_r;
   assign drop_count = drop_count_r;
   assign fifo_level = level_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_tx_order_framer.sv
// -----------------------------------------------------------------------------
// tb_tx_order_framer
//
// Directed self-checking bench for tx_order_framer (DEPTH=4, SYNC_BYTE=A5).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Frame length follows TX_FRAMER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_tx_order_framer;

`ifdef TX_FRAMER_CHECKSUM_EN
   localparam int FLEN = 8;
`else
   localparam int FLEN = 7;
`endif

   logic        clk;
   logic        reset;
   logic [7:0]  tx_addr;
   logic [7:0]  tx_buysell;
   logic [31:0] tx_timestamp;
   logic        tx_dv;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [15:0] drop_count;
   logic [2:0]  fifo_level;
   logic        busy;

   int checks;
   int errors;

   tx_order_framer #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .reset(reset),
      .tx_addr(tx_addr), .tx_buysell(tx_buysell), .tx_timestamp(tx_timestamp), .tx_dv(tx_dv),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .drop_count(drop_count), .fifo_level(fifo_level), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one record for exactly one rising edge
   task automatic push_rec(input logic [7:0] a, input logic [7:0] bs, input logic [31:0] ts);
      @(negedge clk);
      tx_addr = a; tx_buysell = bs; tx_timestamp = ts; tx_dv = 1'b1;
      @(posedge clk);
      #1 tx_dv = 1'b0;
   endtask

   // Receive one frame; toggle stalls every other cycle, no_gap demands valid on every cycle
   task automatic recv_frame(input logic [7:0] a, input logic [7:0] bs, input logic [31:0] ts,
                             input bit toggle, input bit no_gap);
      logic [7:0] exp [8];
      int k;
      int cyc;
      exp[0] = 8'hA5; exp[1] = a; exp[2] = bs;
      exp[3] = ts[31:24]; exp[4] = ts[23:16]; exp[5] = ts[15:8]; exp[6] = ts[7:0];
      exp[7] = a ^ bs ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
      k = 0;
      cyc = 0;
      while (k < FLEN) begin
         @(negedge clk);
         out_ready = toggle ? ~out_ready : 1'b1;
         if (out_valid) begin
            checks++;
            if (out_data !== exp[k]) begin
               errors++;
               $display("FAIL frame_byte%0d: got %02h expected %02h", k, out_data, exp[k]);
            end
            checks++;
            if (out_last !== (k == FLEN - 1)) begin
               errors++;
               $display("FAIL frame_last%0d: got %0b expected %0b", k, out_last, (k == FLEN - 1));
            end
            if (out_ready) k++;
         end else if (no_gap) begin
            checks++;
            errors++;
            $display("FAIL frame_gap%0d: got out_valid 0 expected 1", k);
         end
         cyc++;
         if (cyc > 64) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d bytes expected %0d", k, FLEN);
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_last",  32'(out_last),  32'd0);
      chk("rst_drop",  32'(drop_count), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      reset = 1'b0;
   endtask

   task automatic test_single;
      out_ready = 1'b1;
      push_rec(8'h00, 8'h02, 32'h12345678);
      @(negedge clk);
      chk("single_lat_valid", 32'(out_valid), 32'd0);
      chk("single_level",     32'(fifo_level), 32'd1);
      recv_frame(8'h00, 8'h02, 32'h12345678, 1'b0, 1'b1);
      @(negedge clk);
      chk("single_end_valid", 32'(out_valid), 32'd0);
      chk("single_end_busy",  32'(busy),      32'd0);
   endtask

   task automatic test_filter;
      push_rec(8'h33, 8'h00, 32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("filter_valid", 32'(out_valid), 32'd0);
      end
      chk("filter_level", 32'(fifo_level), 32'd0);
      chk("filter_drop",  32'(drop_count), 32'd0);
      chk("filter_busy",  32'(busy),       32'd0);
   endtask

   task automatic test_overflow;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push_rec(8'(8'h10 + i), 8'(1 + (i % 2)), 32'hA0B0C000 + 32'(i));
      end
      @(negedge clk);
      chk("ovf_drop",  32'(drop_count), 32'd1);
      chk("ovf_level", 32'(fifo_level), 32'd4);
      chk("ovf_busy",  32'(busy),       32'd1);
      chk("ovf_valid", 32'(out_valid),  32'd1);
      for (int i = 0; i < 5; i++) begin
         recv_frame(8'(8'h10 + i), 8'(1 + (i % 2)), 32'hA0B0C000 + 32'(i), 1'b0, 1'b1);
      end
      @(negedge clk);
      chk("ovf_end_valid", 32'(out_valid),  32'd0);
      chk("ovf_end_level", 32'(fifo_level), 32'd0);
   endtask

   task automatic test_toggle;
      out_ready = 1'b0;
      push_rec(8'h7E, 8'h01, 32'h0F1E2D3C);
      recv_frame(8'h7E, 8'h01, 32'h0F1E2D3C, 1'b1, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("toggle_end_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      push_rec(8'h21, 8'h02, 32'h11223344);
      push_rec(8'h22, 8'h01, 32'h55667788);
      push_rec(8'h23, 8'h02, 32'h99AABBCC);
      @(negedge clk);
      chk("mid_level", 32'(fifo_level), 32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) @(negedge clk);
      out_ready = 1'b0;
      chk("mid_byte3", 32'(out_data), 32'h11);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_valid", 32'(out_valid),  32'd0);
      chk("mid_rst_level", 32'(fifo_level), 32'd0);
      chk("mid_rst_drop",  32'(drop_count), 32'd0);
      chk("mid_rst_busy",  32'(busy),       32'd0);
      push_rec(8'h5A, 8'h01, 32'hCAFEF00D);
      recv_frame(8'h5A, 8'h01, 32'hCAFEF00D, 1'b0, 1'b0);
      @(negedge clk);
      chk("mid_after_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      tx_addr = 8'h00; tx_buysell = 8'h00; tx_timestamp = 32'h0; tx_dv = 1'b0;
      out_ready = 1'b0;
      test_reset;
      test_single;
      test_filter;
      test_overflow;
      test_toggle;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
